// File: rtl/cube_root_checker.sv
// cube_root_checker: recomputes r^3 and (r+1)^3 for an (N, r) pair with a
// sequential shift-add multiplier and reports whether r is floor(cbrt(N)),
// along with r^3 and N - r^3. Valid/ready handshake on both sides.
// Optional feature macro: CUBE_CHECK_COUNT_EN adds a saturating fail_count.
module cube_root_checker #(
   parameter int unsigned NUM_W  = 32,
   parameter int unsigned ROOT_W = 12,
   localparam int unsigned CW    = 3 * ROOT_W + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NUM_W-1:0]  number_in,
   input  logic [ROOT_W-1:0] root_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW-1:0]     cube_out,
   output logic [CW-1:0]     remainder_out,
   output logic              pass,
   output logic              too_high,
`ifdef CUBE_CHECK_COUNT_EN
   output logic [15:0]       fail_count,
`endif
   output logic              too_low
);

   localparam int unsigned CNT_W = $clog2(ROOT_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQUARE,
      S_CUBE,
      S_CHECK,
      S_HOLD
   } state_t;

   state_t             r_state;
   logic [NUM_W-1:0]   r_n;
   logic [ROOT_W-1:0]  r_root;
   logic [CNT_W-1:0]   r_cnt;
   logic [CW-1:0]      r_acc;
   logic [CW-1:0]      r_sq;

   logic [CW-1:0]      w_mcand;
   logic [CW-1:0]      w_partial;
   logic [CW-1:0]      w_acc_sum;
   logic [CW-1:0]      w_n_ext;
   logic [CW-1:0]      w_sq3;
   logic [CW-1:0]      w_r3;
   logic [CW-1:0]      w_next;
   logic               w_last;
   logic               w_too_high;
   logic               w_too_low;

   // Shift-add step and the (r+1)^3 = r^3 + 3r^2 + 3r + 1 comparison terms
   always_comb begin
      w_mcand    = (r_state == S_CUBE) ? r_sq : CW'(r_root);
      w_partial  = r_root[r_cnt] ? (w_mcand << r_cnt) : '0;
      w_acc_sum  = r_acc + w_partial;
      w_n_ext    = CW'(r_n);
      w_sq3      = (r_sq << 1) + r_sq;
      w_r3       = (CW'(r_root) << 1) + CW'(r_root);
      w_next     = r_acc + w_sq3 + w_r3 + CW'(1);
      w_last     = (r_cnt == CNT_W'(ROOT_W - 1));
      w_too_high = (r_acc > w_n_ext);
      w_too_low  = !w_too_high && (w_next <= w_n_ext);
   end

   // Control FSM, multiplier datapath and registered result outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_n           <= '0;
         r_root        <= '0;
         r_cnt         <= '0;
         r_acc         <= '0;
         r_sq          <= '0;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         cube_out      <= '0;
         remainder_out <= '0;
         pass          <= 1'b0;
         too_high      <= 1'b0;
         too_low       <= 1'b0;
`ifdef CUBE_CHECK_COUNT_EN
         fail_count    <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  r_n      <= number_in;
                  r_root   <= root_in;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  in_ready <= 1'b0;
                  r_state  <= S_SQUARE;
               end
            end
            S_SQUARE: begin
               if (w_last) begin
                  r_sq    <= w_acc_sum;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_CUBE;
               end else begin
                  r_acc   <= w_acc_sum;
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
            end
            S_CUBE: begin
               r_acc <= w_acc_sum;
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= S_CHECK;
               end else begin
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
            end
            S_CHECK: begin
               cube_out      <= r_acc;
               remainder_out <= w_too_high ? '0 : (w_n_ext - r_acc);
               too_high      <= w_too_high;
               too_low       <= w_too_low;
               pass          <= !w_too_high && !w_too_low;
               out_valid     <= 1'b1;
               r_state       <= S_HOLD;
`ifdef CUBE_CHECK_COUNT_EN
               if ((w_too_high || w_too_low) && (fail_count != 16'hFFFF))
                  fail_count <= fail_count + 16'd1;
`endif
            end
            S_HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cube_root_checker.sv
// Directed + randomized bench for cube_root_checker against an arithmetic
// reference model (direct cubes in 64-bit integers).
module tb_cube_root_checker;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] number_in;
   logic [11:0] root_in;
   logic        out_valid;
   logic        out_ready;
   logic [36:0] cube_out;
   logic [36:0] remainder_out;
   logic        pass;
   logic        too_high;
   logic        too_low;
`ifdef CUBE_CHECK_COUNT_EN
   logic [15:0] fail_count;
`endif

   int checks   = 0;
   int failures = 0;

   longint unsigned exp_cube, exp_rem, prev_cube;
   logic            exp_pass, exp_hi, exp_lo;
   int              exp_fails;

   cube_root_checker dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .number_in     (number_in),
      .root_in       (root_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .cube_out      (cube_out),
      .remainder_out (remainder_out),
      .pass          (pass),
      .too_high      (too_high),
`ifdef CUBE_CHECK_COUNT_EN
      .fail_count    (fail_count),
`endif
      .too_low       (too_low)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned cube64(input longint unsigned r);
      return r * r * r;
   endfunction

   function automatic int unsigned icbrt(input longint unsigned n);
      int unsigned r = 0;
      while (cube64(longint'(r) + 1) <= n) r++;
      return r;
   endfunction

   // Reference: floor-cube-root classification straight from the definitions
   task automatic set_exp(input longint unsigned n, input int unsigned r);
      longint unsigned c, nx;
      c  = cube64(longint'(r));
      nx = cube64(longint'(r) + 1);
      exp_cube = c;
      exp_hi   = (c > n);
      exp_lo   = !exp_hi && (nx <= n);
      exp_pass = !exp_hi && !exp_lo;
      exp_rem  = exp_hi ? 0 : n - c;
      if (!exp_pass && exp_fails < 65535) exp_fails++;
   endtask

   task automatic send(input longint unsigned n, input int unsigned r);
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      number_in = n[31:0];
      root_in   = r[11:0];
      set_exp(n, r);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      number_in = $urandom;
      root_in   = 12'($urandom);
   endtask

   task automatic check_result(input string tag);
      check({tag, "_cube"}, 64'(cube_out), exp_cube);
      check({tag, "_rem"},  64'(remainder_out), exp_rem);
      check({tag, "_pass"}, 64'(pass), 64'(exp_pass));
      check({tag, "_hi"},   64'(too_high), 64'(exp_hi));
      check({tag, "_lo"},   64'(too_low), 64'(exp_lo));
`ifdef CUBE_CHECK_COUNT_EN
      check({tag, "_fcnt"}, 64'(fail_count), 64'(exp_fails));
`endif
   endtask

   // Waits for the result (bounded), checks latency and values, optional
   // backpressure with a competing pair held on the input, then handshakes.
   task automatic collect(input string tag, input int hold, input bit pend,
                          input longint unsigned pn, input int unsigned pr);
      int cycles = 0;
      while (out_valid !== 1'b1 && cycles < 60) begin
         if (cycles == 5) begin
            check({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_busy_cube"}, 64'(cube_out), prev_cube);
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      check({tag, "_latency"}, 64'(cycles), 64'd25);
      check_result(tag);
      if (pend) begin
         @(negedge clk);
         in_valid  = 1'b1;
         number_in = pn[31:0];
         root_in   = pr[11:0];
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
         check({tag, "_hold_cube"},  64'(cube_out), exp_cube);
         check({tag, "_hold_rem"},   64'(remainder_out), exp_rem);
         check({tag, "_hold_pass"},  64'(pass), 64'(exp_pass));
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_hs_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_hs_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_post_cube"}, 64'(cube_out), exp_cube);
      prev_cube = exp_cube;
   endtask

   task automatic run(input string tag, input longint unsigned n,
                      input int unsigned r, input int hold);
      send(n, r);
      collect(tag, hold, 1'b0, 0, 0);
   endtask

   initial begin
      longint unsigned n;
      int unsigned     r, rf;
      int              ov_seen;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      number_in = '0;
      root_in   = '0;
      exp_fails = 0;
      prev_cube = 0;
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_cube", 64'(cube_out), 64'd0);
      check("rst_rem", 64'(remainder_out), 64'd0);
      check("rst_flags", 64'({pass, too_high, too_low}), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed cases
      run("n27",   64'd27, 3, 0);
      run("nmax",  64'hFFFF_FFFF, 1625, 2);
      run("n1000", 64'd1000, 9, 0);
      run("n4000", 64'd4000, 17, 1);
      run("zero",  64'd0, 0, 0);
      run("rmax",  64'hFFFF_FFFF, 4095, 0);

      // Backpressure with a competing pair held during HOLD
      send(64'd125, 5);
      collect("bp", 10, 1'b1, 64'd64, 4);
      set_exp(64'd64, 4);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      collect("bp_next", 0, 1'b0, 0, 0);

      // Randomized pairs around the true floor root
      for (int k = 0; k < 10; k++) begin
         n  = longint'($urandom);
         rf = icbrt(n);
         case ($urandom_range(0, 3))
            0: r = rf;
            1: r = rf + 1;
            2: r = (rf > 0) ? rf - 1 : rf;
            default: r = $urandom_range(0, 4095);
         endcase
         send(n, r);
         collect("rand", $urandom_range(0, 3), 1'b0, 0, 0);
      end

      // Reset mid-computation aborts the pair
      send(64'd1331, 11);
      repeat (12) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_cube", 64'(cube_out), 64'd0);
      check("mid_rst_rem", 64'(remainder_out), 64'd0);
      check("mid_rst_flags", 64'({pass, too_high, too_low}), 64'd0);
      exp_fails = 0;
      prev_cube = 0;
`ifdef CUBE_CHECK_COUNT_EN
      check("mid_rst_fcnt", 64'(fail_count), 64'd0);
`endif
      @(negedge clk);
      reset   = 1'b0;
      ov_seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) ov_seen++;
      end
      check("mid_rst_no_output", 64'(ov_seen), 64'd0);
      run("after_rst", 64'd1331, 11, 0);
      run("after_rst2", 64'd2000, 13, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
